// File: rtl/matrix_key_emu.sv
// Matrix keypad key-press emulator: answers a row scanner on the column lines
// and plays back a press with optional contact bounce, hold, release and gap.
module matrix_key_emu #(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned BOUNCE_CYCLES = 50000,
  parameter int unsigned BOUNCE_PHASES = 4,
  parameter int unsigned GAP_MS        = 20
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold_ms,
  input  logic       abort,
  output logic       busy,
  output logic       pressed,
  output logic [3:0] cur_key,
  output logic       done
);

  localparam int unsigned CNT_MAX = (TICK_DIV > BOUNCE_CYCLES) ? TICK_DIV : BOUNCE_CYCLES;
  localparam int unsigned CYC_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned PH_W    = (BOUNCE_PHASES < 2) ? 1 : $clog2(BOUNCE_PHASES);
  localparam logic [CYC_W-1:0] TICK_LAST = CYC_W'(TICK_DIV - 1);
  localparam logic [CYC_W-1:0] BNC_LAST  = CYC_W'(BOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BOUNCE_PHASES - 1);
  localparam logic [7:0]       GAP_LAST  = 8'(GAP_MS - 1);
  localparam bit               HAS_BNC   = (BOUNCE_PHASES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BNC_PRESS,
    S_HOLD,
    S_BNC_REL,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [7:0]       ms_q, ms_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       cur_key_q, cur_key_d;
  logic [3:0]       col_q, col_d;
  logic             pressed_q, pressed_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // State register and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      ms_q      <= '0;
      phase_q   <= '0;
      hold_q    <= '0;
      cur_key_q <= '0;
      col_q     <= 4'hF;
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ms_q      <= ms_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      cur_key_q <= cur_key_d;
      col_q     <= col_d;
      pressed_q <= pressed_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Next-state, timing counters and output decode
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ms_d      = ms_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    cur_key_d = cur_key_q;
    done_d    = 1'b0;
    pressed_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_key_d = cmd_key;
          hold_d    = cmd_hold_ms;
          cyc_d     = '0;
          ms_d      = '0;
          phase_d   = '0;
          if (cmd_hold_ms == 8'd0) done_d = 1'b1;
          else state_d = HAS_BNC ? S_BNC_PRESS : S_HOLD;
        end
      end
      S_BNC_PRESS, S_BNC_REL: begin
        if (cyc_q == BNC_LAST) begin
          cyc_d = '0;
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            state_d = (state_q == S_BNC_PRESS) ? S_HOLD : S_GAP;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_HOLD, S_GAP: begin
        if (cyc_q == TICK_LAST) begin
          cyc_d = '0;
          if (ms_q == ((state_q == S_HOLD) ? hold_q - 8'd1 : GAP_LAST)) begin
            ms_d = '0;
            if (state_q == S_HOLD) begin
              state_d = HAS_BNC ? S_BNC_REL : S_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            ms_d = ms_q + 8'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops the contact at once and still enforces a full open gap
    if (abort && (state_q == S_BNC_PRESS || state_q == S_HOLD || state_q == S_BNC_REL)) begin
      state_d = S_GAP;
      cyc_d   = '0;
      ms_d    = '0;
      phase_d = '0;
    end

    unique case (state_d)
      S_BNC_PRESS: pressed_d = ~phase_d[0];
      S_HOLD:      pressed_d = 1'b1;
      S_BNC_REL:   pressed_d = phase_d[0];
      default:     pressed_d = 1'b0;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);

    col_d = 4'hF;
    if (pressed_q && !row[cur_key_q[3:2]]) col_d[cur_key_q[1:0]] = 1'b0;
  end

  assign col       = col_q;
  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign pressed   = pressed_q;
  assign cur_key   = cur_key_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_key_emu.sv
// Directed bench for matrix_key_emu: one instance without bounce, one with.
module tb_matrix_key_emu;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic       cmd_valid, cmd_valid_b;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold_ms;
  logic       abort, abort_b;

  logic [3:0] col_a, cur_key_a, col_b, cur_key_b;
  logic       cmd_ready_a, busy_a, pressed_a, done_a;
  logic       cmd_ready_b, busy_b, pressed_b, done_b;

  int checks = 0;
  int errors = 0;

  logic       pr_h   [0:255];
  logic       done_h [0:255];
  logic       busy_h [0:255];
  logic [3:0] col_h  [0:255];

  always #5 sys_clk = ~sys_clk;

  matrix_key_emu #(.TICK_DIV(10), .BOUNCE_CYCLES(3), .BOUNCE_PHASES(0), .GAP_MS(2)) u_dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .row(row), .col(col_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_key(cmd_key),
    .cmd_hold_ms(cmd_hold_ms), .abort(abort), .busy(busy_a), .pressed(pressed_a),
    .cur_key(cur_key_a), .done(done_a)
  );

  matrix_key_emu #(.TICK_DIV(10), .BOUNCE_CYCLES(3), .BOUNCE_PHASES(4), .GAP_MS(2)) u_dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .row(row), .col(col_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_key(cmd_key),
    .cmd_hold_ms(cmd_hold_ms), .abort(abort_b), .busy(busy_b), .pressed(pressed_b),
    .cur_key(cur_key_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // First step is the accept edge; command offers are withdrawn after it
  task automatic capture(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        cmd_valid   = 1'b0;
        cmd_valid_b = 1'b0;
      end
      pr_h[i]   = (which == 0) ? pressed_a : pressed_b;
      done_h[i] = (which == 0) ? done_a    : done_b;
      busy_h[i] = (which == 0) ? busy_a    : busy_b;
      col_h[i]  = (which == 0) ? col_a     : col_b;
    end
  endtask

  function automatic int cnt_pr(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (pr_h[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (busy_h[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (done_h[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_col(input int lo, input int hi, input logic [3:0] v);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (col_h[i] === v) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int i = 0; i < n; i++) if (done_h[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [11:0] pr_bits(input int lo);
    logic [11:0] v;
    for (int i = 0; i < 12; i++) v[11-i] = pr_h[lo+i];
    return v;
  endfunction

  task automatic wait_idle_a(input string tag, input int budget);
    int n = 0;
    while (busy_a !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(busy_a), 32'd0);
  endtask

  initial begin
    logic [3:0] kk, e;
    int         n;
    int         bad;

    rst_n = 1'b0; row = 4'hF; cmd_valid = 1'b0; cmd_valid_b = 1'b0;
    cmd_key = 4'd0; cmd_hold_ms = 8'd0; abort = 1'b0; abort_b = 1'b0;
    repeat (3) step();
    check("rst col", 32'(col_a), 32'hF);
    check("rst pressed", 32'(pressed_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst ready", 32'(cmd_ready_a), 32'd1);
    check("rst done", 32'(done_a), 32'd0);
    check("rst cur_key", 32'(cur_key_a), 32'd0);
    rst_n = 1'b1;
    step();
    check("post-rst ready", 32'(cmd_ready_a), 32'd1);

    // Basic press, no bounce: key 6 on row 1, col 2
    row = 4'b1101; cmd_key = 4'd6; cmd_hold_ms = 8'd3; cmd_valid = 1'b1;
    capture(0, 60);
    check("basic pressed@0", 32'(pr_h[0]), 32'd1);
    check("basic pressed cycles", 32'(cnt_pr(0, 59)), 32'd30);
    check("basic col low cycles", 32'(cnt_col(0, 59, 4'b1011)), 32'd30);
    check("basic col idle cycles", 32'(cnt_col(0, 59, 4'hF)), 32'd30);
    check("basic busy cycles", 32'(cnt_busy(0, 59)), 32'd50);
    check("basic done count", 32'(cnt_done(0, 59)), 32'd1);
    check("basic done index", 32'(first_done(60)), 32'd50);
    check("basic cur_key", 32'(cur_key_a), 32'd6);

    // Same press with the key's row not driven
    row = 4'b1110; cmd_valid = 1'b1;
    capture(0, 60);
    check("undriven col idle", 32'(cnt_col(0, 59, 4'hF)), 32'd60);
    check("undriven pressed cycles", 32'(cnt_pr(0, 59)), 32'd30);

    // Bounce instance: 4 phases of 3 cycles on press and release
    row = 4'b1101; cmd_key = 4'd6; cmd_hold_ms = 8'd3; cmd_valid_b = 1'b1;
    capture(1, 80);
    check("bounce press pattern", 32'(pr_bits(0)), 32'hE38);
    check("bounce hold cycles", 32'(cnt_pr(12, 41)), 32'd30);
    check("bounce release pattern", 32'(pr_bits(42)), 32'h1C7);
    check("bounce gap open", 32'(cnt_pr(54, 79)), 32'd0);
    check("bounce done index", 32'(first_done(80)), 32'd74);
    check("bounce col closed", 32'(col_h[7]), 32'b1011);
    check("bounce col open", 32'(col_h[4]), 32'hF);

    // Zero hold: no press, done right after accept
    row = 4'b0111; cmd_key = 4'd15; cmd_hold_ms = 8'd0; cmd_valid = 1'b1;
    capture(0, 10);
    check("zero done@0", 32'(done_h[0]), 32'd1);
    check("zero done count", 32'(cnt_done(0, 9)), 32'd1);
    check("zero pressed", 32'(cnt_pr(0, 9)), 32'd0);
    check("zero col idle", 32'(cnt_col(0, 9, 4'hF)), 32'd10);
    check("zero busy", 32'(cnt_busy(0, 9)), 32'd0);
    check("zero cur_key", 32'(cur_key_a), 32'd15);

    // Abort mid-hold with a new command offered throughout the gap
    row = 4'b1101; cmd_key = 4'd5; cmd_hold_ms = 8'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (9) step();
    check("abort pre pressed", 32'(pressed_a), 32'd1);
    abort = 1'b1; cmd_valid = 1'b1; cmd_key = 4'd9; cmd_hold_ms = 8'd1;
    step();
    abort = 1'b0;
    check("abort pressed", 32'(pressed_a), 32'd0);
    check("abort busy", 32'(busy_a), 32'd1);
    check("abort cur_key", 32'(cur_key_a), 32'd5);
    n = 0; bad = 0;
    while (done_a !== 1'b1 && n < 40) begin
      step();
      n++;
      if (done_a !== 1'b1 && (cur_key_a !== 4'd5 || cmd_ready_a !== 1'b0)) bad++;
    end
    check("abort gap length", 32'(n), 32'd20);
    check("abort offer held off", 32'(bad), 32'd0);
    check("abort done ready", 32'(cmd_ready_a), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("queued accept busy", 32'(busy_a), 32'd1);
    check("queued accept key", 32'(cur_key_a), 32'd9);
    check("queued accept pressed", 32'(pressed_a), 32'd1);
    wait_idle_a("queued idle", 60);

    // Scanner-style row rotation for every key
    for (int k = 0; k < 16; k++) begin
      kk = 4'(k);
      row = 4'hF; cmd_key = kk; cmd_hold_ms = 8'd10; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      for (int r = 0; r < 4; r++) begin
        row = ~(4'b0001 << r);
        step();
        e = 4'hF;
        if (kk[3:2] == 2'(r)) e[kk[1:0]] = 1'b0;
        check($sformatf("scan k%0d r%0d", k, r), 32'(col_a), 32'(e));
      end
      row = 4'hF; abort = 1'b1;
      step();
      abort = 1'b0;
      wait_idle_a($sformatf("scan idle k%0d", k), 40);
    end

    // Reset asserted mid-hold
    row = 4'b1101; cmd_key = 4'd6; cmd_hold_ms = 8'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (9) step();
    check("mid pressed", 32'(pressed_a), 32'd1);
    rst_n = 1'b0;
    repeat (3) step();
    check("mid rst col", 32'(col_a), 32'hF);
    check("mid rst pressed", 32'(pressed_a), 32'd0);
    check("mid rst busy", 32'(busy_a), 32'd0);
    check("mid rst cur_key", 32'(cur_key_a), 32'd0);
    check("mid rst ready", 32'(cmd_ready_a), 32'd1);
    check("mid rst done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid post ready", 32'(cmd_ready_a), 32'd1);
    check("mid post busy", 32'(busy_a), 32'd0);
    check("mid post col", 32'(col_a), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_key_emu.md
MATRIX_KEY_EMU -- requirements
Module: matrix_key_emu

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, sys_clk cycles per 1 ms tick.
REQ-002 SHALL have parameter BOUNCE_CYCLES, default 50000, sys_clk cycles per contact-bounce phase.
REQ-003 SHALL have parameter BOUNCE_PHASES, default 4, number of bounce phases; even, 0 means no bounce.
REQ-004 SHALL have parameter GAP_MS, default 20, contact-open time in ms after each release.
REQ-005 SHALL have port sys_clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port row  in  4  keypad row drive from scanner, active-low.
REQ-008 SHALL have port col  out  4  emulated keypad column response, active-low.
REQ-009 SHALL have port cmd_valid  in  1  press command offered.
REQ-010 SHALL have port cmd_ready  out  1  command can be accepted.
REQ-011 SHALL have port cmd_key  in  4  key code 0-15.
REQ-012 SHALL have port cmd_hold_ms  in  8  stable-closed hold time in ms.
REQ-013 SHALL have port abort  in  1  cancel current press.
REQ-014 SHALL have port busy  out  1  press sequence in progress.
REQ-015 SHALL have port pressed  out  1  current emulated contact state, 1 = closed.
REQ-016 SHALL have port cur_key  out  4  key code of last accepted command.
REQ-017 SHALL have port done  out  1  one-cycle pulse at sequence end.

Function
REQ-018 SHALL map key k to row index k[3:2] and column index k[1:0].
REQ-019 SHALL register col: col(t+1)[k[1:0]] = 0 when pressed(t)=1 and row(t)[k[3:2]]=0; all other col bits = 1.
REQ-020 SHALL treat any row value with the key's row bit low as driven, including multiple low bits.
REQ-021 SHALL implement states IDLE, BNC_PRESS, HOLD, BNC_REL, GAP.
REQ-022 SHALL drive cmd_ready=1 only in IDLE and busy=1 in every state except IDLE.
REQ-023 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1, latching cmd_key into cur_key and cmd_hold_ms.
REQ-024 SHALL, on accept with hold_ms=0, skip the press, stay in IDLE, and pulse done in the next cycle; pressed stays 0.
REQ-025 SHALL, on accept with hold_ms>0, enter BNC_PRESS, or HOLD when BOUNCE_PHASES=0, with pressed=1 from the next cycle.
REQ-026 SHALL in BNC_PRESS run BOUNCE_PHASES phases of BOUNCE_CYCLES cycles each, alternating closed/open starting closed, then enter HOLD.
REQ-027 SHALL in HOLD keep pressed=1 for exactly hold_ms*TICK_DIV cycles, then enter BNC_REL, or GAP when BOUNCE_PHASES=0.
REQ-028 SHALL in BNC_REL run BOUNCE_PHASES phases alternating open/closed starting open, then enter GAP.
REQ-029 SHALL in GAP keep pressed=0 for GAP_MS*TICK_DIV cycles, then return to IDLE with done=1 for that one cycle.
REQ-030 SHALL, on abort=1 in BNC_PRESS, HOLD or BNC_REL, set pressed=0 next cycle and enter GAP with a full gap count.
REQ-031 SHALL ignore abort in IDLE and GAP; an abort coincident with a command accept in IDLE SHALL NOT affect that command.
REQ-032 SHALL ignore cmd_valid while busy; the offer SHALL NOT be consumed.
REQ-033 SHALL count time with a cycle counter 0..TICK_DIV-1 plus an 8-bit ms counter, with no overflow for hold_ms=255.

Reset
REQ-034 SHALL on rst_n=0 at any time, including mid-sequence, force IDLE, col=4'b1111, pressed=0, busy=0, done=0, cur_key=0, all counters 0.
REQ-035 SHALL drive cmd_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-036 Reset: hold rst_n low 3 cycles during HOLD -> col=1111, pressed=0, busy=0, cur_key=0, cmd_ready=1.
REQ-037 Basic (TICK_DIV=10, BOUNCE_PHASES=0, GAP_MS=2): key 6, hold 3, row=1101 -> col=1011 for 30 cycles; row=1110 -> col=1111; 20 GAP cycles; done pulses once.
REQ-038 Bounce (BOUNCE_PHASES=4, BOUNCE_CYCLES=3): pressed after accept = 111000111000, then 1 for the hold; release = 000111000111, then 0.
REQ-039 Zero hold: key 15, hold 0 -> pressed never 1, col=1111 always, done 1 cycle after accept.
REQ-040 Abort: abort mid-HOLD -> pressed=0 next cycle, then GAP_MS*TICK_DIV cycles, then done; cmd_valid held during busy accepted only on return to IDLE.
REQ-041 Full scan: a scanner-style row rotation 1110/1101/1011/0111 with key 0..15 each -> col low bit equals k[1:0] only while row bit k[3:2] is low.
